// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: one W-bit down-counter shared by N requesters.
// A round-robin arbiter grants one requester at a time over valid/ready. The
// granted length is loaded into the counter and run down to zero, then a
// one-cycle done pulse goes back to that requester. An IDLE cycle always
// separates two grants.
// Optional feature: define SHARED_TIMER_ABORT_EN to add the abort/abort_ack
// ports, which cancel a running delay without issuing done.
module shared_timer_arbiter #(
    parameter int N  = 4,
    parameter int W  = 10,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_len,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [IW-1:0]  grant_id,
    output logic [W-1:0]   count
`ifdef SHARED_TIMER_ABORT_EN
    ,
    input  logic           abort,
    output logic           abort_ack
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, rr_nx;
    logic [IW-1:0] grant_nx;
    logic [W-1:0]  count_nx;
    logic [N-1:0]  done_nx;
    logic          found;
    logic [IW-1:0] sel_idx;
    int            idx;
`ifdef SHARED_TIMER_ABORT_EN
    logic          ack_nx;
`endif

    // Round-robin pick: first valid requester after the last one served
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req_valid[IW'(idx)]) begin
                found   = 1'b1;
                sel_idx = IW'(idx);
            end
        end
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[sel_idx] = 1'b1;
    end

    // Next-state logic: grant in IDLE, count down in RUN, finish or abort
    always_comb begin
        state_nx = state;
        count_nx = count;
        grant_nx = grant_id;
        rr_nx    = rr_ptr;
        done_nx  = '0;
`ifdef SHARED_TIMER_ABORT_EN
        ack_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // found implies req_valid & req_ready on that index
                if (found) begin
                    count_nx = req_len[sel_idx*W +: W];
                    grant_nx = sel_idx;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // Expiry takes precedence over a coincident abort
                if (count == '0) begin
                    done_nx[grant_id] = 1'b1;
                    state_nx          = IDLE;
                    rr_nx             = grant_id;
                end
`ifdef SHARED_TIMER_ABORT_EN
                else if (abort) begin
                    ack_nx   = 1'b1;
                    state_nx = IDLE;
                    rr_nx    = grant_id;
                end
`endif
                else begin
                    count_nx = count - W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register; rr_ptr resets to N-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            grant_id <= '0;
            rr_ptr   <= IW'(N - 1);
            done     <= '0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            grant_id <= grant_nx;
            rr_ptr   <= rr_nx;
            done     <= done_nx;
        end
    end

`ifdef SHARED_TIMER_ABORT_EN
    // Abort acknowledge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) abort_ack <= 1'b0;
        else        abort_ack <= ack_nx;
    end
`endif

    assign busy = (state == RUN);

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
// Define SHARED_TIMER_ABORT_EN to also exercise abort/abort_ack.
module tb_shared_timer_arbiter;
    localparam int N  = 4;
    localparam int W  = 10;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   done;
    logic           busy;
    logic [IW-1:0]  grant_id;
    logic [W-1:0]   count;
`ifdef SHARED_TIMER_ABORT_EN
    logic           abort = 1'b0;
    logic           abort_ack;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shared_timer_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len),
        .req_ready(req_ready), .done(done), .busy(busy), .grant_id(grant_id),
        .count(count)
`ifdef SHARED_TIMER_ABORT_EN
        , .abort(abort), .abort_ack(abort_ack)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec rule: search upward from rr+1 (mod N) for the first valid requester
    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int k = 1; k <= N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    // A delay of length L is tracked as "elapsed cycles since grant"; done
    // arrives once elapsed reaches L, and the visible count is L - elapsed.
    bit           m_busy;
    int           m_len, m_el, m_grant, m_rr, m_p;
    logic [W-1:0] m_count;
    logic [N-1:0] m_done;
    bit           m_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_count = '0; m_done = '0; m_grant = 0; m_rr = N - 1;
            m_ack = 0; m_len = 0; m_el = 0;
        end else begin
            m_done = '0;
            m_ack  = 0;
            if (!m_busy) begin
                m_p = pick(req_valid, m_rr);
                if (m_p >= 0) begin
                    m_busy = 1; m_grant = m_p; m_el = 0;
                    m_len = int'(req_len[m_p*W +: W]);
                    m_count = W'(m_len);
                end
            end else if (m_el == m_len) begin
                m_done[m_grant] = 1'b1; m_busy = 0; m_rr = m_grant;
            end
`ifdef SHARED_TIMER_ABORT_EN
            else if (abort) begin
                m_ack = 1; m_busy = 0; m_rr = m_grant;
            end
`endif
            else begin
                m_el++;
                m_count = W'(m_len - m_el);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit           prev_busy;
    logic [N-1:0] exp_ready;
    int           c_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 0;
        end else begin
            exp_ready = '0;
            if (!m_busy) begin
                c_p = pick(req_valid, m_rr);
                if (c_p >= 0) exp_ready[c_p] = 1'b1;
            end
            chk("count", count, m_count);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("grant_id", grant_id, m_grant);
            chk("req_ready", req_ready, exp_ready);
`ifdef SHARED_TIMER_ABORT_EN
            chk("abort_ack", abort_ack, m_ack);
`endif
            chk("inv_done_onehot", ($countones(done) <= 1), 1);
            if (done != '0) chk("inv_done_after_busy", prev_busy, 1);
            if (req_ready != '0) chk("inv_ready_not_busy", busy, 0);
            prev_busy = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_len(input int i, input int l);
        req_len[i*W +: W] = W'(l);
    endtask

    int ndone;

    initial begin
        // Reset state
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_grant", grant_id, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single request, len 5 -> count 5..0, done at edge 7
        step();
        req_valid = 4'b0001; set_len(0, 5);
        #1 chk("t1_ready", req_ready, 4'b0001);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) req_valid = '0;
            chk("t1_count", count, (k <= 6) ? 6 - k : 0);
            chk("t1_busy", busy, (k <= 6));
            chk("t1_done", done, (k == 7) ? 4'b0001 : 4'b0000);
        end

        // 2: all valid, len 2 -> grants 0,1,2,3,0 every 4 cycles
        do_reset();
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_len(i, 2);
        for (int j = 1; j <= 20; j++) begin
            step();
            if ((j - 1) % 4 == 0) begin
                chk("t2_grant", grant_id, ((j - 1) / 4) % 4);
                chk("t2_busy", busy, 1);
                chk("t2_count", count, 2);
            end
            if (j % 4 == 0) chk("t2_done", done, 4'b0001 << ((j / 4 - 1) % 4));
            if (j == 17) req_valid = '0;
        end

        // 3: len 0 on requester 2 -> done the cycle after the handshake
        step();
        req_valid = 4'b0100; set_len(2, 0);
        #1 chk("t3_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        chk("t3_grant", grant_id, 2);
        chk("t3_count0", count, 0);
        step();
        chk("t3_done", done, 4'b0100);
        chk("t3_count1", count, 0);

        // 4: max length 2^W-1 runs 2^W cycles, no wrap, one done
        step();
        req_valid = 4'b0001; set_len(0, 1023);
        ndone = 0;
        for (int k = 1; k <= 1026; k++) begin
            step();
            if (k == 1) req_valid = '0;
            if (done != '0) ndone++;
            if (k <= 1024) chk("t4_count", count, 1024 - k);
            if (k == 1025) chk("t4_done", done, 4'b0001);
        end
        chk("t4_ndone", ndone, 1);

        // 5: reset mid-RUN at count 3 -> outputs clear, requester 0 first after
        step();
        req_valid = 4'b0010; set_len(1, 8);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) req_valid = '0;
        end
        chk("t5_count3", count, 3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_grant", grant_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        req_valid = 4'b0011; set_len(0, 1); set_len(1, 1);
        step();
        req_valid = '0;
        chk("t5_grant0", grant_id, 0);
        chk("t5_busy", busy, 1);
        repeat (3) step();

`ifdef SHARED_TIMER_ABORT_EN
        // 6a: abort at count 4 -> abort_ack next cycle, no done
        req_valid = 4'b0001; set_len(0, 6);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) req_valid = '0;
        end
        chk("t6_count4", count, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_ack", abort_ack, 1);
        chk("t6_nodone", done, 0);
        chk("t6_busy", busy, 0);
        step();
        // 6b: abort coincident with count==0 -> done only
        req_valid = 4'b0001; set_len(0, 2);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) req_valid = '0;
        end
        chk("t6b_count0", count, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6b_done", done, 4'b0001);
        chk("t6b_noack", abort_ack, 0);
        step();
`endif

        // Random traffic: the compare process checks every cycle
        for (int c = 0; c < 4000; c++) begin
            step();
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                set_len(i, ($urandom_range(0, 199) == 0) ? $urandom_range(0, 1023)
                                                         : $urandom_range(0, 12));
`ifdef SHARED_TIMER_ABORT_EN
            abort = ($urandom_range(0, 9) == 0);
`endif
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        req_valid = '0;
`ifdef SHARED_TIMER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
